// File: rtl/checkpoint_monitor_pkg.sv
// checkpoint_monitor_pkg: sequencer state encoding and fail codes shared by checkpoint_monitor
package checkpoint_monitor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
    localparam logic [1:0] FAIL_ORDER   = 2'b10;
    localparam logic [1:0] FAIL_ABORT   = 2'b11;
endpackage

// File: rtl/signal_qualifier.sv
// signal_qualifier: synchronises an async bus and strobes once each time a value has held STABLE samples
module signal_qualifier #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] check_i,
    output logic             qual_stb,
    output logic [WIDTH-1:0] qual_val
);
    localparam int CW = $clog2(STABLE + 1);
    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] last;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             same;
    assign same   = sync[SYNC_STAGES-1] == last;
    assign cnt_nx = !same ? CW'(1) : (cnt == CW'(STABLE)) ? cnt : cnt + 1'b1;
    // a held value saturates the counter, so it can never strobe a second time
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            last     <= '0;
            cnt      <= '0;
            qual_stb <= 1'b0;
            qual_val <= '0;
        end else begin
            sync[0] <= check_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            last     <= sync[SYNC_STAGES-1];
            cnt      <= cnt_nx;
            qual_stb <= cnt_nx == CW'(STABLE) && (!same || cnt != CW'(STABLE));
            qual_val <= sync[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: matches a qualified status field against programmed checkpoints in order,
// with optional timeout and strict-order detection and a sticky pass/fail verdict.
module checkpoint_monitor
    import checkpoint_monitor_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_W   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_wdata,
    input  logic [$clog2(DEPTH):0]   cfg_count,
    input  logic [TIMEOUT_W-1:0]     timeout_limit,
    input  logic                     strict,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         check_i,
    output logic                     busy,
    output logic                     match_stb,
    output logic [$clog2(DEPTH):0]   progress,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0]     slot [DEPTH];
    state_t               state;
    logic [PW-1:0]        count_q, count_in;
    logic [TIMEOUT_W-1:0] limit_q, tcnt;
    logic                 strict_q, qual_stb, cur_hit, ord_hit;
    logic [WIDTH-1:0]     qual_val;

    signal_qualifier #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .STABLE(STABLE)) u_qual (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .check_i (check_i),
        .qual_stb(qual_stb),
        .qual_val(qual_val)
    );

    assign count_in = int'(cfg_count) > DEPTH ? PW'(DEPTH) : cfg_count;

    // cur_hit: expected slot; ord_hit: any later armed slot (only meaningful when cur_hit is clear)
    always_comb begin
        cur_hit = 1'b0;
        ord_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cur_hit |= qual_val == slot[i] && int'(progress) == i;
            ord_hit |= qual_val == slot[i] && int'(progress) < i && i < int'(count_q);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
        end else if (cfg_we && state != RUN) begin
            for (int i = 0; i < DEPTH; i++) if (int'(cfg_addr) == i) slot[i] <= cfg_wdata;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            strict_q  <= 1'b0;
            tcnt      <= '0;
            progress  <= '0;
            fail_code <= FAIL_NONE;
            match_stb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            match_stb <= 1'b0;
            if (state != RUN) begin
                if (start && !abort) begin
                    count_q   <= count_in;
                    limit_q   <= timeout_limit;
                    strict_q  <= strict;
                    tcnt      <= '0;
                    progress  <= '0;
                    fail_code <= FAIL_NONE;
                    state     <= count_in == '0 ? PASS : RUN;
                    busy      <= count_in != '0;
                    done      <= count_in == '0;
                    pass      <= count_in == '0;
                end
            end else if (abort) begin
                state     <= FAIL;
                fail_code <= FAIL_ABORT;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else if (qual_stb && cur_hit) begin
                match_stb <= 1'b1;
                progress  <= progress + 1'b1;
                tcnt      <= '0;
                if (progress + 1'b1 == count_q) begin
                    state <= PASS;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end
            end else if (strict_q && qual_stb && ord_hit) begin
                state     <= FAIL;
                fail_code <= FAIL_ORDER;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else if (limit_q != '0 && tcnt == limit_q) begin
                state     <= FAIL;
                fail_code <= FAIL_TIMEOUT;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else if (!(&tcnt)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_checkpoint_monitor.sv
// tb_checkpoint_monitor: directed stimulus with a queued scoreboard of expected match/verdict events
module tb_checkpoint_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [2:0]  cfg_count = '0;
    logic [23:0] timeout_limit = '0;
    logic        strict = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] check_i = '0;
    logic        busy, match_stb, done, pass;
    logic [2:0]  progress;
    logic [1:0]  fail_code;

    checkpoint_monitor dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_count(cfg_count), .timeout_limit(timeout_limit),
        .strict(strict), .start(start), .abort(abort), .check_i(check_i),
        .busy(busy), .match_stb(match_stb), .progress(progress), .done(done),
        .pass(pass), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int prog;
        int ps;
        int code;
        int cyc;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_tot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", n, act, act, exp, exp, cyc);
    endtask

    task automatic exp_match(input int prog, input int at);
        ev_t e;
        e = '{is_done: 1'b0, prog: prog, ps: 0, code: 0, cyc: at};
        q.push_back(e);
    endtask

    task automatic exp_done(input int ps, input int code, input int prog, input int at);
        ev_t e;
        e = '{is_done: 1'b1, prog: prog, ps: ps, code: code, cyc: at};
        q.push_back(e);
    endtask

    task automatic take(input bit d);
        ev_t e;
        if (q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected %s event: progress %0d pass %0d code %0d at cycle %0d, none expected",
                     d ? "verdict" : "match", progress, pass, fail_code, cyc);
            return;
        end
        e = q.pop_front();
        chk(d ? "verdict kind" : "match kind", int'(d), int'(e.is_done));
        chk(d ? "verdict progress" : "match progress", int'(progress), e.prog);
        chk(d ? "verdict cycle" : "match cycle", cyc, e.cyc);
        if (d) begin
            chk("verdict pass", int'(pass), e.ps);
            chk("verdict fail_code", int'(fail_code), e.code);
            chk("verdict busy", int'(busy), 0);
        end
    endtask

    logic [3:0] prev_st = '0;
    always @(negedge clk) begin
        if (match_stb) take(1'b0);
        if (done && {done, pass, fail_code} != prev_st) take(1'b1);
        prev_st = {done, pass, fail_code};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic arm(input logic [2:0] c, input logic [23:0] lim, input logic s);
        cfg_count = c;
        timeout_limit = lim;
        strict = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic idle_outputs(input string n);
        chk({n, " busy"}, int'(busy), 0);
        chk({n, " done"}, int'(done), 0);
        chk({n, " pass"}, int'(pass), 0);
        chk({n, " progress"}, int'(progress), 0);
        chk({n, " fail_code"}, int'(fail_code), 0);
        chk({n, " match_stb"}, int'(match_stb), 0);
    endtask

    task automatic do_abort(input int prog);
        exp_done(0, 3, prog, cyc + 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
    endtask

    task automatic two_step_pass();
        tick(2);
        exp_match(1, cyc + 5);
        check_i = 16'hAB60;
        tick(8);
        exp_match(2, cyc + 5);
        exp_done(1, 0, 2, cyc + 5);
        check_i = 16'hAB61;
        tick(8);
    endtask

    initial begin
        tick(3);
        idle_outputs("reset");
        rst = 1'b0;
        tick(5);

        wr(2'd0, 16'hAB60);
        wr(2'd1, 16'hAB61);
        arm(3'd2, 24'd0, 1'b0);
        chk("armed busy", int'(busy), 1);
        two_step_pass();

        check_i = 16'h0000;
        tick(8);
        exp_done(0, 1, 0, cyc + 102);
        arm(3'd2, 24'd100, 1'b0);
        tick(100);
        chk("busy before timeout", int'(busy), 1);
        tick(4);

        wr(2'd2, 16'hAB62);
        arm(3'd3, 24'd0, 1'b1);
        tick(2);
        exp_done(0, 2, 0, cyc + 5);
        check_i = 16'hAB62;
        tick(8);

        check_i = 16'h0000;
        tick(8);
        arm(3'd3, 24'd0, 1'b0);
        tick(2);
        check_i = 16'hAB62;
        tick(12);
        chk("non-strict busy", int'(busy), 1);
        chk("non-strict progress", int'(progress), 0);

        check_i = 16'h0000;
        tick(8);
        check_i = 16'hAB60;
        tick(1);
        check_i = 16'h0000;
        tick(10);
        chk("glitch progress", int'(progress), 0);
        exp_match(1, cyc + 5);
        check_i = 16'hAB60;
        tick(2);
        check_i = 16'h0000;
        tick(8);
        do_abort(1);

        arm(3'd3, 24'd0, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(2);
        idle_outputs("mid-run reset");
        rst = 1'b0;
        tick(5);
        arm(3'd2, 24'd0, 1'b0);
        check_i = 16'hAB60;
        tick(12);
        chk("cleared slots progress", int'(progress), 0);
        chk("cleared slots busy", int'(busy), 1);
        do_abort(0);

        check_i = 16'h0000;
        tick(8);
        wr(2'd0, 16'hAB60);
        wr(2'd1, 16'hAB61);
        arm(3'd2, 24'd0, 1'b0);
        two_step_pass();

        arm(3'd2, 24'd0, 1'b0);
        chk("re-arm busy", int'(busy), 1);
        chk("re-arm progress", int'(progress), 0);
        chk("re-arm done", int'(done), 0);
        do_abort(0);
        exp_done(1, 0, 0, cyc + 1);
        arm(3'd0, 24'd0, 1'b0);
        tick(5);

        chk("pending events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/checkpoint_monitor.md
# checkpoint_monitor

Parametrised hardware checkpoint sequencer for the user project. It watches a WIDTH-bit status field (normally the firmware-driven mprj_io check bits) and expects up to DEPTH programmed checkpoint values in order. An optional per-checkpoint timeout and an optional strict-order check are supported. It reports progress and a sticky pass/fail verdict with a fail code, so firmware tests can be self-checked on silicon as well as in simulation.

## Interface
Parameters:
- WIDTH, 16, width of observed field and checkpoint values
- DEPTH, 4, number of checkpoint slots (≥1)
- TIMEOUT_W, 24, width of timeout counter/limit
- SYNC_STAGES, 2, synchroniser flops on check_i (≥2)
- STABLE, 2, consecutive equal synchronised samples required to qualify a value (≥1)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- cfg_we  in  1  write checkpoint slot (ignored while RUN)
- cfg_addr  in  $clog2(DEPTH)  slot index; out-of-range writes ignored
- cfg_wdata  in  WIDTH  expected value
- cfg_count  in  $clog2(DEPTH)+1  checkpoints to arm, sampled on start; >DEPTH clamped to DEPTH
- timeout_limit  in  TIMEOUT_W  max cycles between checkpoints; 0 disables; sampled on start
- strict  in  1  enable out-of-order detection; sampled on start
- start  in  1  arm pulse
- abort  in  1  abort pulse
- check_i  in  WIDTH  asynchronous observed field
- busy  out  1  state == RUN
- match_stb  out  1  one-cycle pulse per checkpoint matched
- progress  out  $clog2(DEPTH)+1  checkpoints matched so far
- done  out  1  state is PASS or FAIL
- pass  out  1  state == PASS
- fail_code  out  2  00 none, 01 timeout, 10 order, 11 abort

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: start → RUN if the latched count ≥1; start with count 0 → PASS.
- PASS/FAIL: outputs hold until the next start. Start re-arms (→RUN, or →PASS for count 0). progress and fail_code clear on start.
- RUN, each cycle, priority order:
  - abort → FAIL, code 11.
  - qualified value == slot[progress] → match_stb=1, progress+1, timeout counter cleared. → PASS when progress+1 == count.
  - strict and qualified value == slot[j] for some progress<j<count and ≠ slot[progress] → FAIL, code 10.
  - limit≠0 and timeout counter == limit → FAIL, code 01.
- A match and a timeout in the same cycle: match wins.
- Abort outside RUN: ignored. Start in RUN: ignored. Start and abort together: abort wins.
- Qualification:
  - The qualified value is the synchronised sample after it has been equal for STABLE consecutive cycles.
  - Each distinct qualified value produces at most one qualification event. Re-qualifying requires a change and a return.
  - This stops a held value from matching two consecutive identical slots without an intervening change.
- Timeout counter: cleared on start and on each match; increments every RUN cycle; saturates.
- Reset: state IDLE, all slots 0, progress 0, fail_code 00, all outputs 0, synchroniser and stability counter cleared.

## Timing
- check_i → match_stb latency: SYNC_STAGES+STABLE cycles after the first clock edge sampling the new value (4 with defaults).
- progress and pass/fail update on the same edge that asserts match_stb or enters FAIL.
- Timeout enters FAIL on the edge where counter == limit, i.e. limit+1 cycles after start or after the last match.
- cfg writes take effect next cycle. start samples cfg_count, limit and strict on its edge.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package checkpoint_monitor_pkg: state encoding (IDLE/RUN/PASS/FAIL) and fail-code constants (FAIL_NONE, FAIL_TIMEOUT, FAIL_ORDER, FAIL_ABORT).
- Sub-module signal_qualifier (WIDTH, SYNC_STAGES, STABLE): synchroniser chain, stability counter, one-shot qualified-value strobe and value.
- Top holds the slot register array, sequencer FSM, timeout counter and strict comparators (DEPTH parallel compares, masked by count and progress).

## Test plan
- Slots {AB60, AB61}, count 2, limit 0: drive AB60 then AB61 → two match_stb pulses, each 4 cycles after the change; pass=1, progress=2, fail_code=00.
- Limit 100, check_i held at 0000 → FAIL with fail_code=01 exactly 101 cycles after start; busy deasserts the same edge.
- Slots {AB60, AB61, AB62}, strict=1, count 3: drive AB62 first → fail_code=10, progress=0. Repeat with strict=0 → no fail, waits.
- Glitch: AB60 held for 1 cycle, then 0000 (STABLE=2) → no match_stb. Held 2 cycles → match.
- Abort at progress 1 → fail_code=11. Then assert wb_rst_i mid-RUN → all outputs 0, slots read back unmatched. Re-program and start → normal pass.
- Count 0 start → pass next cycle. Re-arm from PASS → progress clears to 0, busy=1.
